// File: rtl/pipe_field.sv
// pipe_field: scrolling pipe, gap generator, collision detection, score
// counter and IDLE/RUN/DEAD game-state machine for the play field.
module pipe_field #(
  parameter logic [7:0] SCROLL_RATE = 8'd100,
  parameter logic [3:0] GAP_SIZE    = 4'd4,
  parameter logic [3:0] BIRD_COL    = 4'd3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Start,
  input  logic [3:0] BirdY,
  output logic [3:0] PipeX,
  output logic [3:0] GapTop,
  output logic [7:0] Score,
  output logic       Running,
  output logic       GameOver,
  output logic       Crash
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  tick_cnt;
  logic [7:0]  lfsr;
  logic [3:0]  pipe_x;
  logic [3:0]  gap_top;
  logic [7:0]  score;
  logic        crash_r;

  logic        hit;
  logic        tick;
  logic        lfsr_fb;
  logic [3:0]  new_gap;
  logic [4:0]  bird_y5;
  logic [4:0]  gap_lo;
  logic [4:0]  gap_hi;

  // Score increment that sticks at the 8-bit ceiling.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Gap bounds widened to 5 bits so GapTop+GAP_SIZE-1 cannot wrap.
  assign bird_y5 = {1'b0, BirdY};
  assign gap_lo  = {1'b0, gap_top};
  assign gap_hi  = gap_lo + {1'b0, GAP_SIZE} - 5'd1;

  assign hit = (BirdY == 4'd15) ||
               ((pipe_x == BIRD_COL) && ((bird_y5 < gap_lo) || (bird_y5 > gap_hi)));

  assign tick    = (tick_cnt >= SCROLL_RATE);
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign new_gap = {1'b0, lfsr[2:0]} + 4'd2;

  // Game-state register; only moves on enabled cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else if (Enable) begin
      state <= state_nxt;
    end
  end

  // Next-state decode: Start toggles IDLE->RUN and DEAD->IDLE, a hit ends RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (hit)   state_nxt = DEAD;
      DEAD:    if (Start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Field state: LFSR, scroll counter, pipe position/gap, score and crash flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr     <= 8'hA5;
      tick_cnt <= 8'd0;
      pipe_x   <= 4'd15;
      gap_top  <= 4'd6;
      score    <= 8'd0;
      crash_r  <= 1'b0;
    end else begin
      crash_r <= 1'b0;
      if (Enable) begin
        lfsr <= {lfsr[6:0], lfsr_fb};
        case (state)
          IDLE: begin
            tick_cnt <= 8'd0;
          end
          RUN: begin
            // A hit freezes the field even when a scroll tick lands on the same cycle.
            if (hit) begin
              crash_r <= 1'b1;
            end else if (tick) begin
              tick_cnt <= 8'd0;
              if (pipe_x == BIRD_COL) score <= sat_inc(score);
              if (pipe_x == 4'd0) begin
                pipe_x  <= 4'd15;
                gap_top <= new_gap;
              end else begin
                pipe_x <= pipe_x - 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
          DEAD: begin
            // Returning to IDLE restores the start-of-game field; the LFSR keeps running.
            if (Start) begin
              pipe_x   <= 4'd15;
              gap_top  <= 4'd6;
              score    <= 8'd0;
              tick_cnt <= 8'd0;
            end
          end
          default: begin
            tick_cnt <= 8'd0;
          end
        endcase
      end
    end
  end

  assign PipeX    = pipe_x;
  assign GapTop   = gap_top;
  assign Score    = score;
  assign Running  = (state == RUN);
  assign GameOver = (state == DEAD);
  assign Crash    = crash_r & Enable;

endmodule
